uart_tx_engine: RTL
===================

# uart_tx_engine

UART transmit engine that drains bytes from the team's TX FIFO and serializes them onto the line. It sits between the TX-side FIFO instance (combinational read data, `rd`/`empty` interface, pointer advance on falling clock edge) and the `tx` pin. It generates its own baud ticks and sends one 8N1-style frame per popped byte, with an optional parity bit.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: stop-bit length in baud ticks; 16 is 1 stop bit, 24 is 1.5, 32 is 2.
- `CLK_DIV`, 27: clk cycles per baud tick; one bit lasts 16 ticks. Must be at least 2.
- `PARITY`, 0: 0 is none, 1 is even, 2 is odd.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `tx_en` input 1: when high, the engine may start new frames.
- `fifo_empty` input 1: FIFO `empty` flag.
- `fifo_data` input DBIT: FIFO `r_data`, the head entry, valid whenever `fifo_empty` is 0.
- `fifo_rd` output 1: pop strobe to FIFO `rd`, one cycle wide.
- `tx` output 1: serial line, idles high.
- `tx_busy` output 1: high whenever a frame is in progress.
- `tx_done_tick` output 1: one-cycle pulse at the end of each frame's stop period.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Reset values: state IDLE, `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0, all counters 0.
- Baud divider: a mod-CLK_DIV counter produces `s_tick` when it reaches CLK_DIV-1.
  - The divider is cleared on every load edge, so every bit is exactly 16*CLK_DIV cycles.
- IDLE → START when `tx_en`=1 and `fifo_empty`=0 at a rising edge:
  - `fifo_data` is latched into the shift register `b_reg`.
  - The parity accumulator is cleared.
  - The tick counter `s_cnt`=0 and the bit counter `n`=0.
- START: `tx`=0. On the `s_tick` where `s_cnt`=15, go to DATA with `s_cnt`=0; otherwise `s_cnt` increments on each tick.
- DATA: `tx`=`b_reg[0]`. After 16 ticks:
  - Shift `b_reg` right and XOR the sent bit into parity.
  - `n` increments.
  - When `n`=DBIT-1, go to PAR if PARITY≠0, else go to STOP.
- PAR: `tx` = parity (even: XOR of the data bits; odd: its inverse). After 16 ticks, go to STOP.
- STOP: `tx`=1. On the tick where `s_cnt`=SB_TICK-1, go to IDLE and pulse `tx_done_tick` for 1 cycle.
- `tx_busy` is 1 in every state except IDLE.
- `tx` is registered and must never glitch.
- `tx_en` dropping mid-frame does not abort the frame; it only blocks the next load.
- `fifo_rd` is only ever raised from IDLE with `fifo_empty`=0, so the engine never pops an empty FIFO. Exactly one pop per frame.
- Reset mid-frame:
  - Immediately `tx`=1, state IDLE, `fifo_rd`=0.
  - The byte in flight is discarded; it was already popped.
  - No `tx_done_tick`.

## Timing
- `fifo_rd` is a registered pulse, high for exactly the one clk cycle following the load edge.
  - The FIFO advances its pointer on that cycle's falling edge, after the data was captured.
  - `fifo_empty` is settled before the next rising edge.
- `tx` falls at the load edge, with no cycles of latency from the load decision.
- Frame length: (1+DBIT+(PARITY≠0))*16*CLK_DIV + SB_TICK*CLK_DIV cycles, measured from the load edge to the edge where the state returns to IDLE.
- `tx_done_tick` is high for the cycle following that edge, concurrent with the first IDLE cycle.
- Back-to-back frames with a non-empty FIFO and `tx_en`=1:
  - The next load occurs at the first IDLE edge.
  - The line holds 1 for exactly 1 clk between the end of the stop period and the next start bit.
- `fifo_empty` falling while the engine is busy has no effect until IDLE.

## Test plan
- Single frame: CLK_DIV=4, PARITY=0, push 0xA5, `tx_en`=1.
  - One `fifo_rd` pulse.
  - `tx` = 0, 1,0,1,0,0,1,0,1, then 1, each bit 64 cycles with 64 stop cycles.
  - `tx_done_tick` 1 cycle after a 640-cycle frame.
- Parity: PARITY=1 with 0xA5 → parity bit 0; PARITY=2 with 0xA5 → 1; PARITY=1 with 0x07 → 1. Frame lengthens by 64 cycles.
- Back-to-back: push 0x55 and 0x0F.
  - Two frames, two `fifo_rd` pulses 641 cycles apart.
  - 1-cycle high gap between frames; FIFO empty at the end; no third pop.
- Empty and disabled:
  - FIFO empty: `fifo_rd` stays 0 and `tx` stays 1 for 2000 cycles.
  - `tx_en`=0 with data queued: no pop until `tx_en` rises.
  - `tx_en` falls mid-frame: the frame completes.
- Reset mid-DATA (bit 3 of 0xC3):
  - `tx`=1 and `tx_busy`=0 immediately; no `tx_done_tick`.
  - The next queued byte is sent intact after reset is released.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a show-ahead FIFO and serializes them as
// start / DBIT data (LSB first) / optional parity / stop, with an internal baud divider.
module uart_tx_engine #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int CLK_DIV = 27,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int S_W   = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [S_W-1:0]   BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0]   STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   N_LAST    = N_W'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [DBIT-1:0]  b_q, b_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             done_q, done_d;
  logic             s_tick;

  // Odd parity is the inverse of the running XOR of the data bits.
  function automatic logic parity_bit(input logic acc);
    return (PARITY == 2) ? ~acc : acc;
  endfunction

  assign s_tick       = (div_q == DIV_LAST);
  assign fifo_rd      = rd_q;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

  // tx_d is the line value for the next state, so the pin itself is a flop.
  always_comb begin
    state_d = state_q;
    div_d   = s_tick ? '0 : div_q + 1'b1;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_d = START;
          div_d   = '0;
          s_d     = '0;
          n_d     = '0;
          b_d     = fifo_data;
          par_d   = 1'b0;
          tx_d    = 1'b0;
          rd_d    = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d   = '0;
            b_d   = b_q >> 1;
            par_d = par_q ^ b_q[0];
            n_d   = n_q + 1'b1;
            if (n_q == N_LAST) begin
              if (PARITY != 0) begin
                state_d = PAR;
                tx_d    = parity_bit(par_q ^ b_q[0]);
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              tx_d = b_d[0];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

endmodule
